// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the mmio_periph peripheral block.
//   - register offsets inside the 256-byte peripheral window
//   - memwrite strobe encodings
//   - UART transmitter FSM state type
//   - STATUS register bit positions
//   - divisor clamp helper
package mmio_pkg;

    // Register offsets (byte offset within the window, addr[1:0] ignored).
    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_TXDATA = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_DIV    = 8'h0C;
    localparam logic [7:0] OFF_TIMER  = 8'h10;

    // memwrite strobe encodings.
    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    // UART transmitter states (8N1 framing).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // STATUS register bit positions.
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;
    localparam int ST_CNT_MSB = 15;

    // A divisor below 2 cannot time a bit, so it is raised to 2.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < 16'd2) ? 16'd2 : value;
    endfunction

endpackage

// File: rtl/mmio_periph_uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first.
//   clk, reset : system clock, synchronous active-high reset
//   div        : clocks per bit; sampled when a byte is accepted
//   valid      : a byte is available on data
//   data       : byte to send
//   ready      : transmitter can accept a byte (high only in IDLE)
//   txd        : serial output, idle high
//   busy       : a frame is in progress (state != IDLE)
//   state      : current FSM state, exported for observation
//
// Handshake: a byte transfers on a rising edge where valid && ready are both
// high. ready depends only on the FSM state, never on valid, and valid must
// not depend on ready.
module uart_tx
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] div,
    input  logic        valid,
    input  logic [7:0]  data,
    output logic        ready,
    output logic        txd,
    output logic        busy,
    output uart_state_t state
);

    uart_state_t state_next;
    logic [15:0] baud_cnt;
    logic [15:0] div_lat;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;
    logic        tick;

    // Last clock of the current bit period.
    assign tick = (baud_cnt == 16'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = START;
            START:   if (tick) state_next = DATA;
            DATA:    if (tick && (bit_idx == 3'd7)) state_next = STOP;
            STOP:    if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Baud counter, bit index and shift register. The divisor is latched
    // when a byte is accepted so a DIV write mid-frame only affects the next
    // frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            div_lat  <= 16'd2;
            bit_idx  <= '0;
            shift_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        shift_q  <= data;
                        div_lat  <= div;
                        baud_cnt <= div - 16'd1;
                        bit_idx  <= '0;
                    end
                end
                START: begin
                    baud_cnt <= tick ? (div_lat - 16'd1) : (baud_cnt - 16'd1);
                end
                DATA: begin
                    if (tick) begin
                        baud_cnt <= div_lat - 16'd1;
                        if (bit_idx != 3'd7) begin
                            bit_idx <= bit_idx + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (!tick) baud_cnt <= baud_cnt - 16'd1;
                end
                default: begin
                    baud_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b1;
        txd   = 1'b1;
        case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                txd   = 1'b1;
            end
            START:   txd = 1'b0;
            DATA:    txd = shift_q[0];
            STOP:    txd = 1'b1;
            default: txd = 1'b1;
        endcase
    end

endmodule

// File: rtl/mmio_periph.sv
// mmio_periph: memory-mapped peripheral block for the ktc32 data bus.
//   clk, reset : system clock, synchronous active-high reset
//   memwrite   : write strobe (00 none, 01 byte, 10 half, 11 word)
//   addr       : CPU byte address
//   wd         : write data
//   rd         : read data, combinational, 0 when not selected
//   sel        : addr is inside the 256-byte window at BASE_ADDR
//   led        : LED register
//   txd        : UART serial output, idle high
// Registers: LED (0x00), TXDATA (0x04), STATUS (0x08), DIV (0x0C), TIMER (0x10).
module mmio_periph
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          LED_WIDTH  = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           memwrite,
    input  logic [31:0]          addr,
    input  logic [31:0]          wd,
    output logic [31:0]          rd,
    output logic                 sel,
    output logic [LED_WIDTH-1:0] led,
    output logic                 txd
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    // Decode.
    logic [7:0] off;
    logic       wr_en;
    logic       wr_led, wr_tx, wr_status, wr_div, wr_timer;

    assign sel       = (addr[31:8] == BASE_ADDR[31:8]);
    assign off       = {addr[7:2], 2'b00};
    assign wr_en     = sel && (memwrite != MW_NONE);
    assign wr_led    = wr_en && (off == OFF_LED);
    assign wr_tx     = wr_en && (off == OFF_TXDATA);
    assign wr_status = wr_en && (off == OFF_STATUS);
    assign wr_div    = wr_en && (off == OFF_DIV);
    assign wr_timer  = wr_en && (off == OFF_TIMER);

    // Registers.
    logic [LED_WIDTH-1:0] led_q;
    logic [15:0]          div_q;
    logic [31:0]          timer_q;
    logic                 ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q   <= '0;
            div_q   <= DIV_RESET;
            timer_q <= '0;
        end else begin
            if (wr_led) led_q <= wd[LED_WIDTH-1:0];
            if (wr_div) div_q <= clamp_div(wd[15:0]);
            // A load replaces this cycle's increment; counting resumes next cycle.
            timer_q <= wr_timer ? wd : (timer_q + 32'd1);
        end
    end

    assign led = led_q;

    // TX FIFO. Pointers carry one extra MSB so full and empty are distinct.
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
    logic             full, empty, pop, push_ok, ovf_set;
    logic             uart_ready, uart_busy;
    logic [7:0]       fifo_head;
    uart_state_t      uart_state;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == PTR_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign fifo_head = fifo_mem[rd_ptr[AW-1:0]];
    assign pop       = !empty && uart_ready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // still succeeds then.
    assign push_ok   = wr_tx && (!full || pop);
    assign ovf_set   = wr_tx && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (wr_status && wd[ST_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= wd[7:0];
    end

    uart_tx u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .div   (div_q),
        .valid (!empty),
        .data  (fifo_head),
        .ready (uart_ready),
        .txd   (txd),
        .busy  (uart_busy),
        .state (uart_state)
    );

    // Read-back views.
    logic [31:0] led_word;
    logic [31:0] status_word;

    always_comb begin
        led_word                  = '0;
        led_word[LED_WIDTH-1:0]   = led_q;
        status_word               = '0;
        status_word[ST_FULL]      = full;
        status_word[ST_EMPTY]     = empty;
        status_word[ST_BUSY]      = uart_busy;
        status_word[ST_OVF]       = ovf_q;
        // With a 256-entry FIFO the full count does not fit in 8 bits; the
        // full flag disambiguates.
        status_word[ST_CNT_MSB:ST_CNT_LSB] = 8'(count);
    end

    always_comb begin
        rd = '0;
        if (sel) begin
            case (off)
                OFF_LED:    rd = led_word;
                OFF_STATUS: rd = status_word;
                OFF_DIV:    rd = {16'h0000, div_q};
                OFF_TIMER:  rd = timer_q;
                default:    rd = '0;
            endcase
        end
    end

    // Byte-lane bits and the FSM state are not needed by the decode.
    logic unused_bits;
    assign unused_bits = &{1'b0, addr[1:0], uart_state};

endmodule
